// File: rtl/fpga_debug_monitor_pkg.sv
// Shared constants and helpers for the FPGA debug monitor.
package fpga_debug_monitor_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    // Select-register width; a single-entry range still needs one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpga_debug_monitor_btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, counting debouncer and
// rising-edge detector producing a one-cycle press pulse.
module btn_conditioner
    import fpga_debug_monitor_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_prev;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_stable      <= 1'b0;
            r_stable_prev <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_sync1       <= i_btn;
            r_sync2       <= r_sync1;
            r_stable_prev <= r_stable;
            // Any sample matching the accepted level restarts the run.
            if (r_sync2 != r_stable) begin
                if (r_cnt == CNT_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_stable & ~r_stable_prev;

endmodule

// File: rtl/fpga_debug_monitor.sv
// Debug monitor: clocks the core in HALT/RUN/STEP modes and shows one
// LED-sized slice of a selected observed register.
module fpga_debug_monitor
    import fpga_debug_monitor_pkg::*;
#(
    parameter  int unsigned DATA_W     = 32,
    parameter  int unsigned CHANNELS   = 10,
    parameter  int unsigned LED_W      = 8,
    parameter  int unsigned DIV_W      = 24,
    parameter  int unsigned DEB_CYCLES = 65535,
    localparam int unsigned PAGES      = DATA_W / LED_W,
    localparam int unsigned CHAN_W     = clog2_min1(CHANNELS),
    localparam int unsigned PAGE_W     = clog2_min1(PAGES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic [DIV_W-1:0]             div_val,
    input  logic                         step_btn,
    input  logic                         sel_btn,
    input  logic                         page_btn,
    input  logic [CHANNELS*DATA_W-1:0]   reg_bus,
    output logic                         cpu_en,
    output logic [CHAN_W-1:0]            chan_sel,
    output logic [PAGE_W-1:0]            page,
    output logic [LED_W-1:0]             led,
    output logic [DATA_W-1:0]            step_count
);

    localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(CHANNELS - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

    logic              w_step_press;
    logic              w_sel_press;
    logic              w_page_press;
    logic              w_mode_change;
    logic              w_cpu_en_d;
    logic [DIV_W-1:0]  w_count_d;
    logic [CHAN_W-1:0] w_chan_sel_d;
    logic [PAGE_W-1:0] w_page_d;
    logic [DATA_W-1:0] w_chan_word;
    logic [LED_W-1:0]  w_led_slice;

    logic [1:0]        r_mode_prev;
    logic [DIV_W-1:0]  r_count;
    logic              r_cpu_en;
    logic [CHAN_W-1:0] r_chan_sel;
    logic [PAGE_W-1:0] r_page;
    logic [LED_W-1:0]  r_led;
    logic [DATA_W-1:0] r_step_count;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_step_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (step_btn),
        .o_press (w_step_press)
    );

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_sel_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (sel_btn),
        .o_press (w_sel_press)
    );

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_page_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (page_btn),
        .o_press (w_page_press)
    );

    // Using >= lets a lowered div_val fire at once instead of wrapping.
    always_comb begin
        w_mode_change = (mode != r_mode_prev);
        w_count_d     = '0;
        w_cpu_en_d    = 1'b0;
        if (!w_mode_change) begin
            case (mode)
                MODE_RUN: begin
                    if (r_count >= div_val) begin
                        w_cpu_en_d = 1'b1;
                    end else begin
                        w_count_d = r_count + 1'b1;
                    end
                end
                MODE_STEP: w_cpu_en_d = w_step_press;
                default:   w_cpu_en_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_chan_sel_d = r_chan_sel;
        w_page_d     = r_page;
        if (w_sel_press) begin
            w_chan_sel_d = (r_chan_sel == CHAN_LAST) ? '0 : r_chan_sel + 1'b1;
            w_page_d     = '0;
        end else if (w_page_press) begin
            w_page_d = (r_page == PAGE_LAST) ? '0 : r_page + 1'b1;
        end
    end

    always_comb begin
        w_chan_word = reg_bus[r_chan_sel * DATA_W +: DATA_W];
        w_led_slice = w_chan_word[r_page * LED_W +: LED_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Track mode through reset so a held mode is not seen as a change.
            r_mode_prev  <= mode;
            r_count      <= '0;
            r_cpu_en     <= 1'b0;
            r_chan_sel   <= '0;
            r_page       <= '0;
            r_led        <= '0;
            r_step_count <= '0;
        end else begin
            r_mode_prev  <= mode;
            r_count      <= w_count_d;
            r_cpu_en     <= w_cpu_en_d;
            r_chan_sel   <= w_chan_sel_d;
            r_page       <= w_page_d;
            r_led        <= w_led_slice;
            r_step_count <= r_step_count + DATA_W'(w_cpu_en_d);
        end
    end

    assign cpu_en     = r_cpu_en;
    assign chan_sel   = r_chan_sel;
    assign page       = r_page;
    assign led        = r_led;
    assign step_count = r_step_count;

endmodule

// File: tb/tb_fpga_debug_monitor.sv
// Directed bench for fpga_debug_monitor; cpu_en pulses are checked against a
// scoreboard of expected (cycle, step_count) pairs.
module tb_fpga_debug_monitor;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CHANNELS   = 4;
    localparam int unsigned LED_W      = 8;
    localparam int unsigned DIV_W      = 8;
    localparam int unsigned DEB_CYCLES = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [1:0]                 mode;
    logic [DIV_W-1:0]           div_val;
    logic                       step_btn;
    logic                       sel_btn;
    logic                       page_btn;
    logic [CHANNELS*DATA_W-1:0] reg_bus;
    logic                       cpu_en;
    logic [1:0]                 chan_sel;
    logic [1:0]                 page;
    logic [LED_W-1:0]           led;
    logic [DATA_W-1:0]          step_count;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   n_steps = 0;

    fpga_debug_monitor #(
        .DATA_W     (DATA_W),
        .CHANNELS   (CHANNELS),
        .LED_W      (LED_W),
        .DIV_W      (DIV_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .div_val    (div_val),
        .step_btn   (step_btn),
        .sel_btn    (sel_btn),
        .page_btn   (page_btn),
        .reg_bus    (reg_bus),
        .cpu_en     (cpu_en),
        .chan_sel   (chan_sel),
        .page       (page),
        .led        (led),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pulse(input int at_cyc);
        exp_t e;
        n_steps++;
        e.cyc = at_cyc;
        e.cnt = 32'(n_steps);
        sb.push_back(e);
    endtask

    // One clock; any cpu_en pulse is matched against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (cpu_en !== 1'b0) begin
            vectors++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_cpu_en: observed pulse at cycle %0d expected none", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("cpu_en_cycle", 32'(cyc), 32'(e.cyc));
                check("step_count_at_pulse", step_count, e.cnt);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_btns(input logic s, input logic p, input logic st);
        sel_btn  = s;
        page_btn = p;
        step_btn = st;
        ticks(8);
        sel_btn  = 1'b0;
        page_btn = 1'b0;
        step_btn = 1'b0;
        ticks(8);
    endtask

    initial begin
        int r;
        rst      = 1'b1;
        mode     = 2'b01;
        div_val  = 8'd3;
        step_btn = 1'b0;
        sel_btn  = 1'b0;
        page_btn = 1'b0;
        reg_bus  = {32'hCAFEF00D, 32'hDEADBEEF, 32'h88776655, 32'h44332211};
        ticks(3);
        check("reset_cpu_en", 32'(cpu_en), 32'h0);
        check("reset_chan_sel", 32'(chan_sel), 32'h0);
        check("reset_page", 32'(page), 32'h0);
        check("reset_led", 32'(led), 32'h0);
        check("reset_step_count", step_count, 32'h0);

        // RUN with div_val=3: a pulse every 4th cycle, 5 pulses in 20 cycles.
        rst = 1'b0;
        r   = cyc;
        for (int k = 1; k <= 5; k++) expect_pulse(r + 4 * k);
        ticks(20);
        check("run_step_count_20", step_count, 32'd5);
        check("run_pending", 32'(sb.size()), 32'h0);

        mode = 2'b00;
        ticks(2);
        check("halt_step_count", step_count, 32'd5);
        check("led_ch0_pg0", 32'(led), 32'h11);

        // STEP: 10-cycle press gives one pulse 7 cycles after the drive.
        mode = 2'b10;
        ticks(2);
        step_btn = 1'b1;
        expect_pulse(cyc + 7);
        ticks(10);
        step_btn = 1'b0;
        ticks(10);
        check("step_pending", 32'(sb.size()), 32'h0);

        step_btn = 1'b1;
        ticks(3);
        step_btn = 1'b0;
        ticks(12);
        check("glitch_step_count", step_count, 32'(n_steps));

        // Mode 11 behaves as HALT: step presses are ignored.
        mode = 2'b11;
        ticks(2);
        press_btns(1'b0, 1'b0, 1'b1);
        check("halt11_step_count", step_count, 32'(n_steps));

        press_btns(1'b0, 1'b1, 1'b0);
        check("page_after_press", 32'(page), 32'd1);
        for (int k = 0; k < 5; k++) press_btns(1'b1, 1'b0, 1'b0);
        check("sel_wrap_chan", 32'(chan_sel), 32'd1);
        check("sel_clears_page", 32'(page), 32'd0);

        press_btns(1'b1, 1'b0, 1'b0);
        check("chan2_sel", 32'(chan_sel), 32'd2);
        check("led_ch2_pg0", 32'(led), 32'hEF);

        page_btn = 1'b1;
        ticks(7);
        check("page_update_cycle", 32'(page), 32'd1);
        check("led_latency_old", 32'(led), 32'hEF);
        ticks(1);
        check("led_ch2_pg1", 32'(led), 32'hBE);
        page_btn = 1'b0;
        ticks(8);
        for (int k = 0; k < 3; k++) press_btns(1'b0, 1'b1, 1'b0);
        check("page_wrap", 32'(page), 32'd0);
        check("led_after_wrap", 32'(led), 32'hEF);

        press_btns(1'b0, 1'b1, 1'b0);
        press_btns(1'b1, 1'b1, 1'b0);
        check("both_chan_sel", 32'(chan_sel), 32'd3);
        check("both_page", 32'(page), 32'd0);
        check("led_ch3_pg0", 32'(led), 32'h0D);

        // RUN: count reaches 7 with div_val=10, then div_val drops to 2.
        mode    = 2'b01;
        div_val = 8'd10;
        ticks(8);
        div_val = 8'd2;
        expect_pulse(cyc + 1);
        ticks(1);
        check("lower_div_pending", 32'(sb.size()), 32'h0);

        rst  = 1'b1;
        mode = 2'b00;
        ticks(1);
        check("midrun_rst_cpu_en", 32'(cpu_en), 32'h0);
        check("midrun_rst_chan_sel", 32'(chan_sel), 32'h0);
        check("midrun_rst_page", 32'(page), 32'h0);
        check("midrun_rst_led", 32'(led), 32'h0);
        check("midrun_rst_step_count", step_count, 32'h0);
        rst = 1'b0;
        ticks(3);
        check("post_rst_step_count", step_count, 32'h0);
        check("final_pending", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fpga_debug_monitor.md
FPGA_DEBUG_MONITOR -- requirements
Module: fpga_debug_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each observed register.
REQ-002 SHALL have parameter CHANNELS, default 10, number of observed registers (>=2).
REQ-003 SHALL have parameter LED_W, default 8, display width; DATA_W SHALL be an integer multiple of LED_W; PAGES = DATA_W/LED_W.
REQ-004 SHALL have parameter DIV_W, default 24, width of the divider count.
REQ-005 SHALL have parameter DEB_CYCLES, default 65535, button stable-time in clk cycles.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port mode  input  2  00 HALT, 01 RUN, 10 STEP, 11 treated as HALT.
REQ-009 SHALL have port div_val  input  DIV_W  RUN-mode period minus one.
REQ-010 SHALL have ports step_btn, sel_btn, page_btn  input  1 each  raw asynchronous push-buttons.
REQ-011 SHALL have port reg_bus  input  CHANNELS*DATA_W  flattened register values; channel k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port cpu_en  output  1  one-cycle clock-enable pulse to the core.
REQ-013 SHALL have port chan_sel  output  clog2(CHANNELS)  selected channel.
REQ-014 SHALL have port page  output  clog2(PAGES) (min 1)  selected LED_W slice.
REQ-015 SHALL have port led  output  LED_W  displayed slice.
REQ-016 SHALL have port step_count  output  DATA_W  number of cpu_en pulses issued.

Function
REQ-017 Each button SHALL pass a 2-flop synchroniser, then a debouncer accepting a new level only after DEB_CYCLES consecutive identical samples, then a rising-edge detector giving a one-cycle press pulse.
REQ-018 RUN: divider count SHALL increment each cycle; when count >= div_val, cpu_en=1 that cycle and count clears to 0; div_val=0 gives cpu_en every cycle.
REQ-019 Lowering div_val below the current count SHALL yield cpu_en on the next cycle (no wrap through 2^DIV_W).
REQ-020 STEP: each step press pulse SHALL produce exactly one cpu_en, registered one cycle after the press pulse; presses in RUN/HALT SHALL be ignored.
REQ-021 HALT: cpu_en SHALL stay 0.
REQ-022 Any change of mode SHALL clear the divider count in that cycle and suppress cpu_en in that cycle.
REQ-023 step_count SHALL increment on every cpu_en, wrapping 2^DATA_W-1 -> 0.
REQ-024 sel press SHALL increment chan_sel, wrapping CHANNELS-1 -> 0, and SHALL clear page to 0.
REQ-025 page press SHALL increment page, wrapping PAGES-1 -> 0.
REQ-026 Simultaneous sel and page presses: sel SHALL win (chan_sel+1, page=0).
REQ-027 led SHALL be registered: led = reg_bus[chan_sel*DATA_W + page*LED_W +: LED_W] sampled one cycle earlier (1-cycle latency).

Reset
REQ-028 On rst=1 at a clock edge: cpu_en=0, chan_sel=0, page=0, led=0, step_count=0, divider count=0, debouncer states and synchronisers=0.
REQ-029 rst mid-operation (any mode, any count) SHALL abort pending step pulses; no cpu_en in the cycle following reset deassertion.

Structure
REQ-030 Mode encodings (HALT/RUN/STEP) SHALL be constants in the shared package.
REQ-031 Synchroniser+debouncer+edge-detector SHALL be one sub-module, btn_conditioner, instantiated three times.

Verification
REQ-032 DIV_W=8, div_val=3, mode=RUN after reset -> cpu_en high every 4th cycle; step_count=5 after 20 cycles.
REQ-033 DEB_CYCLES=4, STEP: step_btn high 10 cycles -> exactly one cpu_en; 3-cycle glitch -> none.
REQ-034 CHANNELS=4: 5 sel presses -> chan_sel=1, page=0.
REQ-035 DATA_W=32, LED_W=8, channel 2 = 0xDEADBEEF, chan_sel=2, one page press -> led=0xBE one cycle later; sel+page same cycle -> chan_sel=3, page=0.
REQ-036 RUN, div_val=10, count=7, div_val set to 2 -> cpu_en next cycle; rst asserted mid-RUN -> all outputs 0 next cycle.
